ls_capture: RTL and testbench

- 4-channel logic-analyzer acquisition stage; the stage directly upstream of the channel/wave display path.
- Samples raw probe inputs at a programmable rate into a 960-deep ring buffer, with pre-trigger history and an edge trigger.
- After capture, the display scanner reads samples back by screen column (scan_n, 0..959), oldest sample first.

---
 rtl/ls_capture.sv | 169 ++++++++++++++++
 tb/tb_ls_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ls_capture.sv
// Logic-analyzer acquisition stage: synchronizes probes, samples them at a programmable rate into
// a ring buffer with pre-trigger history, and serves display reads oldest-sample-first.
module ls_capture #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = 960,
  parameter int unsigned DIVW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  din,
  input  logic            arm,
  input  logic [DIVW-1:0] div,
  input  logic [1:0]      trig_ch,
  input  logic [1:0]      trig_mode,
  input  logic [9:0]      pre_cnt,
  output logic            busy,
  output logic            done,
  output logic [9:0]      trig_pos,
  input  logic [9:0]      rd_addr,
  output logic [NCH-1:0]  rd_data
);

  localparam int unsigned AW = 10;
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DepthA   = AW'(DEPTH);

  typedef enum logic [2:0] {StIdle, StPre, StArmed, StPost, StDone} state_e;

  state_e state_q, state_d;

  logic [NCH-1:0]  din_meta_q, din_sync_q, prev_q;
  logic            prev_valid_q;
  logic [DIVW-1:0] div_q, div_cnt_q;
  logic [1:0]      trig_ch_q, trig_mode_q;
  logic [AW-1:0]   pre_q, wptr_q, fill_q, trig_addr_q, post_left_q, start_q;
  logic            busy_q, busy_d, done_q, done_d;
  logic [AW-1:0]   trig_pos_q, trig_pos_d;
  logic [NCH-1:0]  rd_data_q;
  logic [NCH-1:0]  mem [DEPTH];

  logic          arm_ok, capturing, strobe, trig_hit, cur_bit, prev_bit, enter_done;
  logic [AW-1:0] pre_clamp, wptr_inc, post_init, start_base, start_diff, start_calc, rd_idx;
  logic [AW:0]   rd_sum;

  assign arm_ok    = arm && (state_q == StIdle || state_q == StDone);
  assign pre_clamp = (pre_cnt > LastAddr) ? LastAddr : pre_cnt;
  assign capturing = (state_q == StPre) || (state_q == StArmed) || (state_q == StPost);
  assign strobe    = capturing && (div_cnt_q == div_q);
  assign wptr_inc  = (wptr_q == LastAddr) ? '0 : wptr_q + AW'(1);
  assign post_init = LastAddr - pre_q;
  assign cur_bit   = din_sync_q[trig_ch_q];
  assign prev_bit  = prev_q[trig_ch_q];

  always_comb begin
    unique case (trig_mode_q)
      2'b00:   trig_hit = 1'b1;
      2'b01:   trig_hit = prev_valid_q && !prev_bit && cur_bit;
      2'b10:   trig_hit = prev_valid_q && prev_bit && !cur_bit;
      default: trig_hit = prev_valid_q && (prev_bit ^ cur_bit);
    endcase
  end

  // When the trigger lands directly in DONE its address is still in wptr, not trig_addr.
  assign enter_done = (state_d == StDone) && (state_q != StDone);
  assign start_base = (state_q == StArmed) ? wptr_q : trig_addr_q;
  assign start_diff = start_base - pre_q;
  assign start_calc = (start_base >= pre_q) ? start_diff : start_diff + DepthA;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      trig_pos_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      trig_pos_q <= trig_pos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (arm_ok) state_d = (pre_clamp == '0) ? StArmed : StPre;
      StPre:          if (strobe && (fill_q + AW'(1) == pre_q)) state_d = StArmed;
      StArmed:        if (strobe && trig_hit) state_d = (post_init == '0) ? StDone : StPost;
      StPost:         if (strobe && (post_left_q == AW'(1))) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_d     = (state_d == StPre) || (state_d == StArmed) || (state_d == StPost);
    done_d     = (state_d == StDone);
    trig_pos_d = enter_done ? pre_q : trig_pos_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_meta_q   <= '0;
      din_sync_q   <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      div_q        <= '0;
      div_cnt_q    <= '0;
      trig_ch_q    <= '0;
      trig_mode_q  <= '0;
      pre_q        <= '0;
      wptr_q       <= '0;
      fill_q       <= '0;
      trig_addr_q  <= '0;
      post_left_q  <= '0;
      start_q      <= '0;
    end else begin
      din_meta_q <= din;
      din_sync_q <= din_meta_q;
      if (arm_ok) begin
        div_q        <= div;
        trig_ch_q    <= trig_ch;
        trig_mode_q  <= trig_mode;
        pre_q        <= pre_clamp;
        div_cnt_q    <= '0;
        wptr_q       <= '0;
        fill_q       <= '0;
        prev_valid_q <= 1'b0;
      end else begin
        div_cnt_q <= (div_cnt_q == div_q) ? '0 : div_cnt_q + DIVW'(1);
        if (strobe) begin
          wptr_q       <= wptr_inc;
          prev_q       <= din_sync_q;
          prev_valid_q <= 1'b1;
          if (state_q == StPre) fill_q <= fill_q + AW'(1);
          if (state_q == StArmed && trig_hit) begin
            trig_addr_q <= wptr_q;
            post_left_q <= post_init;
          end
          if (state_q == StPost) post_left_q <= post_left_q - AW'(1);
        end
        if (enter_done) start_q <= start_calc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (strobe) mem[wptr_q] <= din_sync_q;
  end

  // start + rd_addr can reach 2*DEPTH-2, so the sum needs one extra bit before folding.
  assign rd_sum = {1'b0, start_q} + {1'b0, rd_addr};
  assign rd_idx = (rd_sum >= {1'b0, DepthA}) ? AW'(rd_sum - {1'b0, DepthA}) : rd_sum[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (state_q == StDone && rd_addr < DepthA) begin
      rd_data_q <= mem[rd_idx];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign trig_pos = trig_pos_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ls_capture.sv
// Scoreboard bench for ls_capture: stimulus pushes expectations, a negedge monitor pops and checks.
module tb_ls_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  din = '0;
  logic        arm = 1'b0;
  logic [15:0] div = '0;
  logic [1:0]  trig_ch = '0;
  logic [1:0]  trig_mode = '0;
  logic [9:0]  pre_cnt = '0;
  logic [9:0]  rd_addr = '0;
  logic        busy, done;
  logic [9:0]  trig_pos;
  logic [3:0]  rd_data;

  ls_capture #(.NCH(4), .DEPTH(960), .DIVW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .arm      (arm),
    .div      (div),
    .trig_ch  (trig_ch),
    .trig_mode(trig_mode),
    .pre_cnt  (pre_cnt),
    .busy     (busy),
    .done     (done),
    .trig_pos (trig_pos),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Probe generator: 0 counts cyc on din[3:0]; 1 ch2 rises at gbase; 2 ch0 falls at gbase.
  int gmode = 0;
  int gbase = 0;
  always @(posedge clk) begin
    #1;
    case (gmode)
      1:       din = (cyc >= gbase) ? 4'b0100 : 4'b0000;
      2:       din = (cyc < gbase) ? 4'b0001 : 4'b0000;
      default: din = 4'(cyc);
    endcase
  end

  localparam int KRd = 0, KBusy = 1, KDone = 2, KPos = 3, KRdNow = 4, KLat = 5;
  typedef struct {
    int kind;
    int addr;
    int exp;
    int act;
  } item_t;
  item_t sb[$];

  logic rd_issue = 1'b0;
  logic rd_pend = 1'b0;
  always @(posedge clk) rd_pend <= rd_issue;

  int n_chk = 0;
  int n_fail = 0;

  always @(negedge clk) begin
    item_t it;
    int    act;
    bit    ok;
    string nm;
    if (rd_pend && sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL rd_data: read with no expectation, got %0d", rd_data);
    end
    while (sb.size() > 0 && (rd_pend || sb[0].kind != KRd)) begin
      it = sb.pop_front();
      if (it.kind == KRd) rd_pend = 1'b0;
      case (it.kind)
        KRd:     begin act = int'(rd_data); nm = $sformatf("rd_data[col %0d]", it.addr); end
        KBusy:   begin act = int'(busy); nm = "busy"; end
        KDone:   begin act = int'(done); nm = "done"; end
        KPos:    begin act = int'(trig_pos); nm = "trig_pos"; end
        KRdNow:  begin act = int'(rd_data); nm = "rd_data(now)"; end
        default: begin act = it.act; nm = "done_latency"; end
      endcase
      ok = (it.kind == KLat) ? (act >= it.exp && act <= it.addr) : (act == it.exp);
      n_chk++;
      if (!ok) begin
        n_fail++;
        if (it.kind == KLat)
          $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, it.exp, it.addr);
        else
          $display("FAIL %s: got %0d, expected %0d", nm, act, it.exp);
      end
    end
  end

  task automatic push_st(input int kind, input int exp);
    sb.push_back('{kind: kind, addr: 0, exp: exp, act: 0});
  endtask

  task automatic rd(input int a, input int e);
    rd_addr = 10'(a);
    sb.push_back('{kind: KRd, addr: a, exp: e, act: 0});
    rd_issue = 1'b1;
    @(posedge clk);
    #1;
    rd_issue = 1'b0;
  endtask

  task automatic arm_cap(input int mode, input int ch, input int pre, input int d, output int a);
    repeat (4) @(posedge clk);
    #1;
    trig_mode = 2'(mode);
    trig_ch   = 2'(ch);
    pre_cnt   = 10'(pre);
    div       = 16'(d);
    arm       = 1'b1;
    a         = cyc + 1;
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic wait_done(input int lo, input int hi);
    int n = 0;
    while (!done && n < hi + 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done) sb.push_back('{kind: KLat, addr: hi, exp: lo, act: n});
    else push_st(KDone, 1);
  endtask

  initial begin
    int a;
    repeat (3) @(posedge clk);
    #1;
    push_st(KBusy, 0);
    push_st(KDone, 0);
    push_st(KPos, 0);
    push_st(KRdNow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Immediate trigger, counting input, one sample per clk.
    gmode = 0;
    arm_cap(0, 0, 0, 0, a);
    wait_done(958, 964);
    push_st(KPos, 0);
    for (int k = 0; k < 960; k++) rd(k, (a - 2 + k) & 15);

    // Rising edge on ch2 with 100 samples of history.
    gmode = 1;
    gbase = cyc + 505;
    arm_cap(1, 2, 100, 0, a);
    wait_done(0, 3000);
    push_st(KPos, 100);
    for (int k = 0; k < 960; k++) rd(k, (k >= 100) ? 4 : 0);

    // Falling edge on ch0 after the ring has wrapped several times.
    gmode = 2;
    gbase = cyc + 2505;
    arm_cap(2, 0, 300, 0, a);
    wait_done(0, 5000);
    push_st(KPos, 300);
    for (int k = 0; k < 960; k++) rd(k, (k < 300) ? 1 : 0);

    // Divider: one strobe per 4 clks.
    gmode = 0;
    arm_cap(0, 0, 0, 3, a);
    wait_done(3836, 3846);
    push_st(KPos, 0);
    for (int k = 0; k < 960; k += 7) rd(k, (a + 1 + 4 * k) & 15);

    // Arm during POST is ignored.
    arm_cap(0, 0, 0, 0, a);
    repeat (200) @(posedge clk);
    #1;
    trig_mode = 2'b01;
    pre_cnt   = 10'd500;
    div       = 16'd7;
    arm       = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
    push_st(KBusy, 1);
    wait_done(0, 2000);
    push_st(KPos, 0);
    rd(0, (a - 2) & 15);
    rd(1, (a - 1) & 15);
    rd(500, (a + 498) & 15);
    rd(959, (a + 957) & 15);

    // Reset in the middle of POST.
    arm_cap(0, 0, 0, 0, a);
    repeat (300) @(posedge clk);
    #1;
    push_st(KBusy, 1);
    rd_addr = 10'd5;
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_st(KBusy, 0);
    push_st(KDone, 0);
    push_st(KPos, 0);
    push_st(KRdNow, 0);
    rst = 1'b0;

    // Re-arm with pre_cnt clamped to 959; trigger sample is the last column.
    arm_cap(0, 0, 1023, 0, a);
    wait_done(958, 964);
    push_st(KPos, 959);
    rd(0, (a - 2) & 15);
    rd(1, (a - 1) & 15);
    rd(958, (a + 956) & 15);
    rd(959, (a + 957) & 15);
    rd(960, 0);
    rd(1023, 0);

    repeat (4) @(posedge clk);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk,
             n_fail + ((sb.size() != 0) ? 1 : 0));
    $finish;
  end

endmodule
